sdram_port_arbiter: RTL and testbench

- Shares the single write/read port of sdram_controller between NUM_PORTS requesters (e.g. video fetch, CPU, DMA).
- Arbitration is round-robin. The block sequences one transaction at a time: a one-cycle request pulse to the controller, then it waits for the matching ack.
- Sits between requester logic and sdram_controller; the controller's oinit_done feeds iinit_done here.
- Adds a per-transaction timeout so a lost ack cannot hang a requester.

---
 rtl/sdram_arb_pkg.sv | 37 +++
 rtl/rr_priority_picker.sv | 38 +++
 rtl/sdram_port_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared definitions for the SDRAM port arbiter: default bus widths, FSM
// state encoding and width helpers for pointer/counter sizing.
package sdram_arb_pkg;

  localparam int DEFAULT_ADDR_W = 22;
  localparam int DEFAULT_DATA_W = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_e;

  function automatic int clog2(input int value);
    int width;
    int one;
    width = 0;
    one   = 1;
    for (int i = 0; i < 31; i++) begin
      if ((one << i) < value) begin
        width = i + 1;
      end else begin
        width = width;
      end
    end
    return width;
  endfunction

  // A counter or index always needs at least one bit, even for a count of 1.
  function automatic int ptr_width(input int count);
    int w;
    w = clog2(count);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: grants the first requester at or after
// the pointer, wrapping modulo NUM_PORTS.
module rr_priority_picker
  import sdram_arb_pkg::*;
#(
  parameter int NUM_PORTS = 3,
  parameter int PTR_W     = ptr_width(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] i_req,
  input  logic [PTR_W-1:0]     i_ptr,
  output logic [NUM_PORTS-1:0] o_grant_oh,
  output logic [PTR_W-1:0]     o_grant_idx
);

  logic             w_found;
  logic [PTR_W-1:0] w_cand;

  // Walk candidates in pointer order; the first live request wins.
  always_comb begin
    o_grant_oh  = {NUM_PORTS{1'b0}};
    o_grant_idx = {PTR_W{1'b0}};
    w_found     = 1'b0;
    w_cand      = {PTR_W{1'b0}};
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_cand = PTR_W'((int'(i_ptr) + i) % NUM_PORTS);
      for (int j = 0; j < NUM_PORTS; j++) begin
        if (!w_found && i_req[j] && (w_cand == PTR_W'(j))) begin
          w_found       = 1'b1;
          o_grant_oh[j] = 1'b1;
          o_grant_idx   = w_cand;
        end else begin
          w_found = w_found;
        end
      end
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing the single sdram_controller read/write port
// among NUM_PORTS requesters, one transaction at a time, with an ack timeout.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NUM_PORTS      = 3,
  parameter int ADDR_W         = DEFAULT_ADDR_W,
  parameter int DATA_W         = DEFAULT_DATA_W,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                        iclk,
  input  logic                        ireset,
  input  logic [NUM_PORTS-1:0]        ireq,
  input  logic [NUM_PORTS-1:0]        iwe,
  input  logic [NUM_PORTS*ADDR_W-1:0] iaddr,
  input  logic [NUM_PORTS*DATA_W-1:0] iwdata,
  output logic [NUM_PORTS-1:0]        oack,
  output logic [NUM_PORTS-1:0]        oerr,
  output logic [DATA_W-1:0]           ordata,
  output logic                        obusy,
  output logic                        owrite_req,
  output logic [ADDR_W-1:0]           owrite_address,
  output logic [DATA_W-1:0]           owrite_data,
  input  logic                        iwrite_ack,
  output logic                        oread_req,
  output logic [ADDR_W-1:0]           oread_address,
  input  logic [DATA_W-1:0]           iread_data,
  input  logic                        iread_ack,
  input  logic                        iinit_done
);

  localparam int PTR_W = ptr_width(NUM_PORTS);
  localparam int CNT_W = ptr_width(TIMEOUT_CYCLES);
  localparam logic [PTR_W-1:0]     PTR_LAST = PTR_W'(NUM_PORTS - 1);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [NUM_PORTS-1:0] ONE_HOT0 = {{(NUM_PORTS-1){1'b0}}, 1'b1};

  arb_state_e            r_state;
  logic [PTR_W-1:0]      r_ptr;
  logic [PTR_W-1:0]      r_grant;
  logic                  r_we;
  logic [ADDR_W-1:0]     r_addr;
  logic [DATA_W-1:0]     r_wdata;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_wack_d;
  logic                  r_rack_d;
  logic                  r_wreq;
  logic                  r_rreq;
  logic [NUM_PORTS-1:0]  r_ack;
  logic [NUM_PORTS-1:0]  r_err;
  logic [DATA_W-1:0]     r_ordata;
  logic                  r_busy;

  arb_state_e            w_state_nxt;
  logic [PTR_W-1:0]      w_ptr_nxt;
  logic [PTR_W-1:0]      w_grant_nxt;
  logic                  w_we_nxt;
  logic [ADDR_W-1:0]     w_addr_nxt;
  logic [DATA_W-1:0]     w_wdata_nxt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic                  w_wreq_nxt;
  logic                  w_rreq_nxt;
  logic [NUM_PORTS-1:0]  w_ack_nxt;
  logic [NUM_PORTS-1:0]  w_err_nxt;
  logic [DATA_W-1:0]     w_ordata_nxt;
  logic                  w_busy_nxt;

  logic [NUM_PORTS-1:0]  w_grant_oh;
  logic [PTR_W-1:0]      w_grant_idx;
  logic                  w_any_req;
  logic [NUM_PORTS-1:0]  w_grant_vec;
  logic                  w_ack_rise;

  rr_priority_picker #(
    .NUM_PORTS (NUM_PORTS),
    .PTR_W     (PTR_W)
  ) u_picker (
    .i_req       (ireq),
    .i_ptr       (r_ptr),
    .o_grant_oh  (w_grant_oh),
    .o_grant_idx (w_grant_idx)
  );

  assign w_any_req   = |w_grant_oh;
  assign w_grant_vec = ONE_HOT0 << r_grant;
  // Only a fresh edge counts; an ack level left over from the previous transaction is ignored.
  assign w_ack_rise  = r_we ? (iwrite_ack & ~r_wack_d) : (iread_ack & ~r_rack_d);

  assign oack           = r_ack;
  assign oerr           = r_err;
  assign ordata         = r_ordata;
  assign obusy          = r_busy;
  assign owrite_req     = r_wreq;
  assign oread_req      = r_rreq;
  assign owrite_address = r_addr;
  assign oread_address  = r_addr;
  assign owrite_data    = r_wdata;

  // FSM state register.
  always_ff @(posedge iclk) begin
    if (ireset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and next-output logic; outputs are computed one cycle ahead and registered.
  always_comb begin
    w_state_nxt  = r_state;
    w_ptr_nxt    = r_ptr;
    w_grant_nxt  = r_grant;
    w_we_nxt     = r_we;
    w_addr_nxt   = r_addr;
    w_wdata_nxt  = r_wdata;
    w_cnt_nxt    = r_cnt;
    w_wreq_nxt   = 1'b0;
    w_rreq_nxt   = 1'b0;
    w_ack_nxt    = {NUM_PORTS{1'b0}};
    w_err_nxt    = {NUM_PORTS{1'b0}};
    w_ordata_nxt = r_ordata;
    w_busy_nxt   = r_busy;
    case (r_state)
      IDLE: begin
        if (iinit_done && w_any_req) begin
          w_grant_nxt = w_grant_idx;
          w_we_nxt    = iwe[w_grant_idx];
          w_addr_nxt  = iaddr[int'(w_grant_idx)*ADDR_W +: ADDR_W];
          w_wdata_nxt = iwdata[int'(w_grant_idx)*DATA_W +: DATA_W];
          w_wreq_nxt  = iwe[w_grant_idx];
          w_rreq_nxt  = ~iwe[w_grant_idx];
          w_busy_nxt  = 1'b1;
          w_state_nxt = ISSUE;
        end else begin
          w_busy_nxt  = 1'b0;
        end
      end
      ISSUE: begin
        w_cnt_nxt   = {CNT_W{1'b0}};
        w_state_nxt = WAIT;
      end
      WAIT: begin
        if (w_ack_rise) begin
          if (!r_we) begin
            w_ordata_nxt = iread_data;
          end else begin
            w_ordata_nxt = r_ordata;
          end
          w_ack_nxt   = w_grant_vec;
          w_state_nxt = DONE;
        end else if (r_cnt == CNT_LAST) begin
          w_ack_nxt   = w_grant_vec;
          w_err_nxt   = w_grant_vec;
          w_state_nxt = DONE;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_W'(1);
        end
      end
      DONE: begin
        w_busy_nxt = 1'b0;
        if (r_grant == PTR_LAST) begin
          w_ptr_nxt = {PTR_W{1'b0}};
        end else begin
          w_ptr_nxt = r_grant + PTR_W'(1);
        end
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Datapath, output and ack-history registers.
  always_ff @(posedge iclk) begin
    if (ireset) begin
      r_ptr    <= {PTR_W{1'b0}};
      r_grant  <= {PTR_W{1'b0}};
      r_we     <= 1'b0;
      r_addr   <= {ADDR_W{1'b0}};
      r_wdata  <= {DATA_W{1'b0}};
      r_cnt    <= {CNT_W{1'b0}};
      r_wack_d <= 1'b0;
      r_rack_d <= 1'b0;
      r_wreq   <= 1'b0;
      r_rreq   <= 1'b0;
      r_ack    <= {NUM_PORTS{1'b0}};
      r_err    <= {NUM_PORTS{1'b0}};
      r_ordata <= {DATA_W{1'b0}};
      r_busy   <= 1'b0;
    end else begin
      r_ptr    <= w_ptr_nxt;
      r_grant  <= w_grant_nxt;
      r_we     <= w_we_nxt;
      r_addr   <= w_addr_nxt;
      r_wdata  <= w_wdata_nxt;
      r_cnt    <= w_cnt_nxt;
      r_wack_d <= iwrite_ack;
      r_rack_d <= iread_ack;
      r_wreq   <= w_wreq_nxt;
      r_rreq   <= w_rreq_nxt;
      r_ack    <= w_ack_nxt;
      r_err    <= w_err_nxt;
      r_ordata <= w_ordata_nxt;
      r_busy   <= w_busy_nxt;
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Scoreboard bench for sdram_port_arbiter: directed scenarios push expected
// controller requests and completions; a monitor pops and compares them.
module tb_sdram_port_arbiter;

  localparam int NP = 3;
  localparam int AW = 22;
  localparam int DW = 128;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } req_t;

  typedef struct {
    logic [NP-1:0] ack;
    logic [NP-1:0] err;
    logic          chk_data;
    logic [DW-1:0] rdata;
    int            min_lat;
    int            max_lat;
  } ack_t;

  typedef struct {
    int            delay;
    logic [DW-1:0] rdata;
  } ctl_t;

  logic             iclk;
  logic             ireset;
  logic [NP-1:0]    ireq;
  logic [NP-1:0]    iwe;
  logic [NP*AW-1:0] iaddr;
  logic [NP*DW-1:0] iwdata;
  logic [NP-1:0]    oack;
  logic [NP-1:0]    oerr;
  logic [DW-1:0]    ordata;
  logic             obusy;
  logic             owrite_req;
  logic [AW-1:0]    owrite_address;
  logic [DW-1:0]    owrite_data;
  logic             iwrite_ack;
  logic             oread_req;
  logic [AW-1:0]    oread_address;
  logic [DW-1:0]    iread_data;
  logic             iread_ack;
  logic             iinit_done;

  req_t exp_req_q[$];
  ack_t exp_ack_q[$];
  ctl_t ctl_q[$];

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int last_req_cyc = 0;
  int req_seen = 0;
  int ack_seen = 0;

  sdram_port_arbiter #(
    .NUM_PORTS      (NP),
    .ADDR_W         (AW),
    .DATA_W         (DW),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .iclk           (iclk),
    .ireset         (ireset),
    .ireq           (ireq),
    .iwe            (iwe),
    .iaddr          (iaddr),
    .iwdata         (iwdata),
    .oack           (oack),
    .oerr           (oerr),
    .ordata         (ordata),
    .obusy          (obusy),
    .owrite_req     (owrite_req),
    .owrite_address (owrite_address),
    .owrite_data    (owrite_data),
    .iwrite_ack     (iwrite_ack),
    .oread_req      (oread_req),
    .oread_address  (oread_address),
    .iread_data     (iread_data),
    .iread_ack      (iread_ack),
    .iinit_done     (iinit_done)
  );

  initial begin
    iclk = 1'b0;
    forever #5 iclk = ~iclk;
  end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  task automatic set_port(input int p, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    iwe[p] = we;
    iaddr[p*AW +: AW] = addr;
    iwdata[p*DW +: DW] = data;
  endtask

  // Expected controller request, controller behaviour and completion for one transaction.
  task automatic expect_txn(input int p, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                            input int delay, input logic [DW-1:0] rdata);
    req_t r;
    ack_t a;
    ctl_t c;
    logic [NP-1:0] one;
    one = 3'b001;
    r.we = we; r.addr = addr; r.data = data;
    c.delay = delay; c.rdata = rdata;
    a.ack = one << p; a.err = 3'b000; a.chk_data = ~we; a.rdata = rdata;
    a.min_lat = delay + 1; a.max_lat = delay + 1;
    exp_req_q.push_back(r);
    ctl_q.push_back(c);
    exp_ack_q.push_back(a);
  endtask

  task automatic wait_req(input int budget, input string name);
    int b;
    b = 0;
    do begin
      @(negedge iclk);
      b++;
    end while (!(owrite_req || oread_req) && b < budget);
    check(name, DW'(owrite_req | oread_req), DW'(1));
  endtask

  // Hold the masked requests until each port has collected n_each acks.
  task automatic run_ports(input logic [NP-1:0] mask, input int n_each, input int budget, input string name);
    int cnt [NP];
    int b;
    for (int p = 0; p < NP; p++) cnt[p] = 0;
    b = 0;
    ireq = ireq | mask;
    while (ireq != 3'b000 && b < budget) begin
      @(negedge iclk);
      b++;
      for (int p = 0; p < NP; p++) begin
        if (oack[p]) begin
          cnt[p]++;
          if (cnt[p] >= n_each) ireq[p] = 1'b0;
        end
      end
    end
    check({name, "_complete"}, DW'(ireq), DW'(0));
  endtask

  // Bench model of sdram_controller: acks each request after its scripted delay (0 = never).
  initial begin : controller
    ctl_t c;
    logic dir;
    iwrite_ack = 1'b0;
    iread_ack  = 1'b0;
    iread_data = {DW{1'b0}};
    forever begin
      @(negedge iclk);
      if (owrite_req || oread_req) begin
        dir = owrite_req;
        if (ctl_q.size() > 0) c = ctl_q.pop_front();
        else c.delay = 0;
        if (c.delay > 0) begin
          repeat (c.delay) @(negedge iclk);
          if (dir) begin
            iwrite_ack = 1'b1;
          end else begin
            iread_ack  = 1'b1;
            iread_data = c.rdata;
          end
          @(negedge iclk);
          iwrite_ack = 1'b0;
          iread_ack  = 1'b0;
        end
      end
    end
  end

  // Scoreboard monitor.
  initial begin : monitor
    req_t er;
    ack_t ea;
    int lat;
    forever begin
      @(negedge iclk);
      cyc++;
      if (owrite_req || oread_req) begin
        req_seen++;
        last_req_cyc = cyc;
        if (exp_req_q.size() == 0) begin
          check("unexpected_req", DW'(1), DW'(0));
        end else begin
          er = exp_req_q.pop_front();
          check("req_excl", DW'(owrite_req & oread_req), DW'(0));
          check("req_dir", DW'(owrite_req), DW'(er.we));
          check("req_wr_addr", DW'(owrite_address), DW'(er.addr));
          check("req_rd_addr", DW'(oread_address), DW'(er.addr));
          if (er.we) check("req_wdata", owrite_data, er.data);
        end
      end
      if (oack != 3'b000) begin
        ack_seen++;
        if (exp_ack_q.size() == 0) begin
          check("unexpected_ack", DW'(oack), DW'(0));
        end else begin
          ea = exp_ack_q.pop_front();
          check("ack_vec", DW'(oack), DW'(ea.ack));
          check("err_vec", DW'(oerr), DW'(ea.err));
          if (ea.chk_data) check("rdata", ordata, ea.rdata);
          lat = cyc - last_req_cyc;
          n_total++;
          if (lat >= ea.min_lat && lat <= ea.max_lat) n_pass++;
          else $display("FAIL ack_latency: actual=%0d required=%0d..%0d", lat, ea.min_lat, ea.max_lat);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int acks_before;
    ireset = 1'b1;
    ireq = 3'b000;
    iwe = 3'b000;
    iaddr = {NP*AW{1'b0}};
    iwdata = {NP*DW{1'b0}};
    iinit_done = 1'b0;
    repeat (3) @(negedge iclk);
    ireset = 1'b0;
    @(negedge iclk);
    check("rst_oack", DW'(oack), DW'(0));
    check("rst_oerr", DW'(oerr), DW'(0));
    check("rst_obusy", DW'(obusy), DW'(0));
    check("rst_reqs", DW'({owrite_req, oread_req}), DW'(0));
    check("rst_ordata", ordata, DW'(0));

    // Init gating, then port 0 read once the controller is ready.
    set_port(0, 1'b0, 22'h000123, 128'd0);
    expect_txn(0, 1'b0, 22'h000123, 128'd0, 4, 128'hA5A5A5A5_5A5A5A5A_11112222_33334444);
    ireq = 3'b001;
    repeat (50) @(negedge iclk);
    check("init_gate_no_req", DW'(req_seen), DW'(0));
    iinit_done = 1'b1;
    @(negedge iclk);
    check("init_req_latency", DW'(oread_req), DW'(1));
    run_ports(3'b001, 1, 40, "init_read");

    // Single write from port 1.
    set_port(1, 1'b1, 22'h000001, 128'hDEADBEEFCAFEBABE123456789ABCDEF0);
    expect_txn(1, 1'b1, 22'h000001, 128'hDEADBEEFCAFEBABE123456789ABCDEF0, 10, 128'd0);
    ireq = 3'b010;
    wait_req(20, "write_req_seen");
    @(negedge iclk);
    check("write_req_one_cycle", DW'(owrite_req), DW'(0));
    check("busy_in_wait", DW'(obusy), DW'(1));
    run_ports(3'b010, 1, 40, "single_write");

    // Read return from port 2.
    set_port(2, 1'b0, 22'h0000A5, 128'd0);
    expect_txn(2, 1'b0, 22'h0000A5, 128'd0, 5, 128'h0123456789ABCDEF0123456789ABCDEF);
    run_ports(3'b100, 1, 40, "read_return");

    // Round robin: all ports request continuously, two transactions each.
    set_port(0, 1'b1, 22'h100000, 128'h00000000_00000000_00000000_00001000);
    set_port(1, 1'b0, 22'h200001, 128'd0);
    set_port(2, 1'b1, 22'h3FFFFF, {DW{1'b1}});
    for (int k = 0; k < 2; k++) begin
      expect_txn(0, 1'b1, 22'h100000, 128'h00000000_00000000_00000000_00001000, 3, 128'd0);
      expect_txn(1, 1'b0, 22'h200001, 128'd0, 3, 128'h77778888_9999AAAA_BBBBCCCC_DDDDEEEE);
      expect_txn(2, 1'b1, 22'h3FFFFF, {DW{1'b1}}, 3, 128'd0);
    end
    run_ports(3'b111, 2, 120, "round_robin");

    // Timeout on port 0 write, then port 1 is granted next.
    begin
      req_t r;
      ack_t a;
      ctl_t c;
      set_port(0, 1'b1, 22'h000040, 128'h40404040_40404040_40404040_40404040);
      set_port(1, 1'b0, 22'h000041, 128'd0);
      r.we = 1'b1; r.addr = 22'h000040; r.data = 128'h40404040_40404040_40404040_40404040;
      exp_req_q.push_back(r);
      c.delay = 0; c.rdata = 128'd0;
      ctl_q.push_back(c);
      a.ack = 3'b001; a.err = 3'b001; a.chk_data = 1'b0; a.rdata = 128'd0;
      a.min_lat = 16; a.max_lat = 18;
      exp_ack_q.push_back(a);
      expect_txn(1, 1'b0, 22'h000041, 128'd0, 3, 128'h41414141_41414141_41414141_41414141);
      run_ports(3'b011, 1, 80, "timeout");
    end

    // Reset in the middle of a port 2 read that is never acked.
    begin
      req_t r;
      ctl_t c;
      set_port(2, 1'b0, 22'h0000C3, 128'd0);
      r.we = 1'b0; r.addr = 22'h0000C3; r.data = 128'd0;
      exp_req_q.push_back(r);
      c.delay = 0; c.rdata = 128'd0;
      ctl_q.push_back(c);
    end
    ireq = 3'b100;
    wait_req(20, "rst_txn_req_seen");
    repeat (3) @(negedge iclk);
    check("busy_before_reset", DW'(obusy), DW'(1));
    acks_before = ack_seen;
    ireset = 1'b1;
    ireq = 3'b000;
    @(negedge iclk);
    check("midrst_reqs", DW'({owrite_req, oread_req}), DW'(0));
    check("midrst_busy", DW'(obusy), DW'(0));
    check("midrst_ack_err", DW'({oack, oerr}), DW'(0));
    check("midrst_addr", DW'({owrite_address, oread_address}), DW'(0));
    check("midrst_ordata", ordata, DW'(0));
    ireset = 1'b0;
    repeat (20) @(negedge iclk);
    check("midrst_no_ack", DW'(ack_seen), DW'(acks_before));

    // After reset the pointer is back at 0, so port 1 wins over port 2.
    set_port(1, 1'b1, 22'h0000B1, 128'hB1B1B1B1_00000000_B1B1B1B1_00000000);
    set_port(2, 1'b0, 22'h0000B2, 128'd0);
    expect_txn(1, 1'b1, 22'h0000B1, 128'hB1B1B1B1_00000000_B1B1B1B1_00000000, 2, 128'd0);
    expect_txn(2, 1'b0, 22'h0000B2, 128'd0, 2, 128'hB2B2B2B2_B2B2B2B2_B2B2B2B2_B2B2B2B2);
    run_ports(3'b110, 1, 60, "post_reset");

    repeat (5) @(negedge iclk);
    check("req_queue_drained", DW'(exp_req_q.size()), DW'(0));
    check("ack_queue_drained", DW'(exp_ack_q.size()), DW'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
